// File: rtl/mcp3_fifo512x064_ctl_pkg.sv
// rtl/mcp3_fifo512x064_ctl_pkg.sv - shared constants, types and helpers for the 512x64 FWFT FIFO controller
package mcp3_fifo_pkg;

    localparam int RAM_DEPTH   = 512;
    localparam int RAM_AW      = 9;
    localparam int DATA_W      = 64;
    localparam int CNT_W       = 10;
    localparam int STAGE_DEPTH = 3;

    typedef logic [1:0]        stage_ptr_t;
    typedef logic [RAM_AW-1:0] ram_addr_t;
    typedef logic [DATA_W-1:0] data_t;
    typedef logic [CNT_W-1:0]  cnt_t;

    // Staging pointers run 0,1,2,0,... (depth 3 is not a power of two).
    function automatic stage_ptr_t stage_ptr_inc(input stage_ptr_t p);
        return (p == stage_ptr_t'(STAGE_DEPTH - 1)) ? stage_ptr_t'(0) : p + stage_ptr_t'(1);
    endfunction

endpackage

// File: rtl/mcp3_fifo512x064_ctl_if.sv
// rtl/mcp3_fifo512x064_ctl_if.sv - write/read valid-ready stream bundle for the FIFO controller
//
// Signals:
//   in_valid/in_ready/in_data    producer -> FIFO stream
//   out_valid/out_ready/out_data FIFO -> consumer stream
// Modports:
//   slave  - the FIFO controller side
//   master - the producer/consumer (environment) side
interface mcp3_fifo512x064_ctl_if;
    import mcp3_fifo_pkg::*;

    logic  in_valid;
    logic  in_ready;
    data_t in_data;
    logic  out_valid;
    logic  out_ready;
    data_t out_data;

    modport slave (
        input  in_valid, in_data, out_ready,
        output in_ready, out_valid, out_data
    );

    modport master (
        output in_valid, in_data, out_ready,
        input  in_ready, out_valid, out_data
    );

endinterface

// File: rtl/mcp3_fifo_stage3.sv
// rtl/mcp3_fifo_stage3.sv - 3-entry circular staging buffer presenting the FIFO head
//
// Ports:
//   clk, reset_n  clock, asynchronous active-low reset
//   push          land push_data at the tail this edge
//   push_data     word returning from the RAM pipe
//   pop           consume the head this edge (only when valid)
//   valid         buffer not empty
//   head_data     head entry, 0 when empty
//   count         occupancy 0..3
module mcp3_fifo_stage3
    import mcp3_fifo_pkg::*;
(
    input  logic       clk,
    input  logic       reset_n,
    input  logic       push,
    input  data_t      push_data,
    input  logic       pop,
    output logic       valid,
    output data_t      head_data,
    output stage_ptr_t count
);

    data_t      entry [STAGE_DEPTH];
    stage_ptr_t head;
    stage_ptr_t tail;
    stage_ptr_t count_q;

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            head    <= '0;
            tail    <= '0;
            count_q <= '0;
            for (int i = 0; i < STAGE_DEPTH; i++) begin
                entry[i] <= '0;
            end
        end else begin
            if (push) begin
                entry[tail] <= push_data;
                tail        <= stage_ptr_inc(tail);
            end
            if (pop) begin
                head <= stage_ptr_inc(head);
            end
            if (push && !pop) begin
                count_q <= count_q + stage_ptr_t'(1);
            end else if (!push && pop) begin
                count_q <= count_q - stage_ptr_t'(1);
            end
        end
    end

    assign valid     = (count_q != '0);
    assign head_data = valid ? entry[head] : '0;
    assign count     = count_q;

    // Read issue is credit-limited upstream, so a push into a full buffer
    // without a simultaneous pop means the credit logic is broken.
    a_no_overflow: assert property (@(posedge clk) disable iff (!reset_n)
        !(push && !pop && (count_q == stage_ptr_t'(STAGE_DEPTH))));

endmodule

// File: rtl/mcp3_ram512x064q.sv
// rtl/mcp3_ram512x064q.sv - 512x64 simple dual-port block RAM with two-cycle registered read
//
// Ports:
//   clk         clock
//   wren/wrad   write enable / address, data written at the rising edge
//   data        write data
//   rden/rdad   read enable / address; q holds mem[rdad] two cycles after rden
//   q           read data
// Contents are not reset.
module mcp3_ram512x064q
    import mcp3_fifo_pkg::*;
(
    input  logic      clk,
    input  logic      wren,
    input  ram_addr_t wrad,
    input  data_t     data,
    input  logic      rden,
    input  ram_addr_t rdad,
    output data_t     q
);

    data_t mem [RAM_DEPTH];
    data_t q1;
    data_t q2;

    always_ff @(posedge clk) begin
        if (wren) begin
            mem[wrad] <= data;
        end
        if (rden) begin
            q1 <= mem[rdad];
        end
        q2 <= q1;
    end

    assign q = q2;

endmodule

// File: rtl/mcp3_fifo512x064_ctl.sv
// rtl/mcp3_fifo512x064_ctl.sv - first-word-fall-through FIFO controller around mcp3_ram512x064q
//
// Ports:
//   clk          clock, all state on the rising edge
//   reset_n      asynchronous active-low reset
//   bus          stream bundle (slave): in_valid/in_ready/in_data, out_valid/out_ready/out_data
//   total_count  RAM words + in-flight reads + staged words (0..515), registered
//   almost_full  total_count >= AFULL_THRESH, registered
//   empty        total_count == 0, registered
//   hwm          high-water mark of total_count
// Build option: define MCP3_FIFO_HWM_EN to enable the hwm register; otherwise hwm is 0.
module mcp3_fifo512x064_ctl
    import mcp3_fifo_pkg::*;
#(
    parameter int AFULL_THRESH = 480
) (
    input  logic                 clk,
    input  logic                 reset_n,
    mcp3_fifo512x064_ctl_if.slave bus,
    output cnt_t                 total_count,
    output logic                 almost_full,
    output logic                 empty,
    output cnt_t                 hwm
);

    logic       in_ready_q;
    ram_addr_t  wr_ptr;
    ram_addr_t  rd_ptr;
    cnt_t       ram_count;
    logic [1:0] rd_pipe;

    logic       ram_wren;
    logic       ram_rden;
    ram_addr_t  ram_wrad;
    ram_addr_t  ram_rdad;
    data_t      ram_q;

    logic       stage_push;
    logic       stage_pop;
    logic       stage_valid;
    stage_ptr_t stage_count;
    data_t      stage_data;

    logic [2:0] committed;
    logic [1:0] inflight_next;
    cnt_t       ram_count_next;
    cnt_t       stage_count_next;
    cnt_t       total_next;

    assign bus.in_ready  = in_ready_q;
    assign bus.out_valid = stage_valid;
    assign bus.out_data  = stage_data;

    assign ram_wren   = bus.in_valid && in_ready_q;
    assign ram_wrad   = wr_ptr;
    assign ram_rdad   = rd_ptr;
    assign stage_pop  = stage_valid && bus.out_ready;
    assign stage_push = rd_pipe[1];

    // Every issued read owns a staging slot until it is popped. A pop this
    // cycle frees one slot, which is what lets a steady 2-in-flight +
    // 1-staged pipeline keep issuing one read per cycle.
    assign committed = 3'(rd_pipe[0]) + 3'(rd_pipe[1]) + 3'(stage_count);
    assign ram_rden  = (ram_count != '0) &&
                       (committed < (3'(STAGE_DEPTH) + 3'(stage_pop)));

    always_comb begin
        ram_count_next = ram_count;
        if (ram_wren && !ram_rden) begin
            ram_count_next = ram_count + cnt_t'(1);
        end else if (!ram_wren && ram_rden) begin
            ram_count_next = ram_count - cnt_t'(1);
        end
        inflight_next    = 2'(ram_rden) + 2'(rd_pipe[0]);
        stage_count_next = cnt_t'(stage_count) + cnt_t'(stage_push) - cnt_t'(stage_pop);
        total_next       = ram_count_next + cnt_t'(inflight_next) + stage_count_next;
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            wr_ptr      <= '0;
            rd_ptr      <= '0;
            ram_count   <= '0;
            rd_pipe     <= '0;
            in_ready_q  <= 1'b0;
            total_count <= '0;
            almost_full <= 1'b0;
            empty       <= 1'b1;
        end else begin
            if (ram_wren) begin
                wr_ptr <= wr_ptr + ram_addr_t'(1);
            end
            if (ram_rden) begin
                rd_ptr <= rd_ptr + ram_addr_t'(1);
            end
            ram_count   <= ram_count_next;
            rd_pipe     <= {rd_pipe[0], ram_rden};
            // Registered from the next count so it is exact every cycle while
            // still being low throughout reset.
            in_ready_q  <= (ram_count_next != cnt_t'(RAM_DEPTH));
            total_count <= total_next;
            almost_full <= (total_next >= cnt_t'(AFULL_THRESH));
            empty       <= (total_next == '0);
        end
    end

`ifdef MCP3_FIFO_HWM_EN
    cnt_t hwm_q;

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            hwm_q <= '0;
        end else if (total_next > hwm_q) begin
            hwm_q <= total_next;
        end
    end

    assign hwm = hwm_q;
`else
    assign hwm = '0;
`endif

    mcp3_ram512x064q u_ram (
        .clk  (clk),
        .wren (ram_wren),
        .wrad (ram_wrad),
        .data (bus.in_data),
        .rden (ram_rden),
        .rdad (ram_rdad),
        .q    (ram_q)
    );

    mcp3_fifo_stage3 u_stage (
        .clk       (clk),
        .reset_n   (reset_n),
        .push      (stage_push),
        .push_data (ram_q),
        .pop       (stage_pop),
        .valid     (stage_valid),
        .head_data (stage_data),
        .count     (stage_count)
    );

    // Reads need ram_count>0 and writes need ram_count<512, so equal
    // pointers with both enables high indicates corrupted bookkeeping.
    a_no_collision: assert property (@(posedge clk) disable iff (!reset_n)
        !(ram_wren && ram_rden && (ram_wrad == ram_rdad)));

endmodule

// File: tb/tb_mcp3_fifo512x064_ctl.sv
// tb/tb_mcp3_fifo512x064_ctl.sv - scoreboard testbench for mcp3_fifo512x064_ctl
module tb_mcp3_fifo512x064_ctl;
    import mcp3_fifo_pkg::*;

`ifdef MCP3_FIFO_HWM_EN
    localparam bit HWM_EN = 1'b1;
`else
    localparam bit HWM_EN = 1'b0;
`endif

    logic clk = 1'b0;
    logic reset_n = 1'b0;
    always #5 clk = ~clk;

    mcp3_fifo512x064_ctl_if bus();
    cnt_t total_count;
    cnt_t hwm;
    logic almost_full;
    logic empty;

    mcp3_fifo512x064_ctl #(.AFULL_THRESH(480)) dut (
        .clk         (clk),
        .reset_n     (reset_n),
        .bus         (bus),
        .total_count (total_count),
        .almost_full (almost_full),
        .empty       (empty),
        .hwm         (hwm)
    );

    int vectors = 0;
    int miscompares = 0;
    logic [63:0] exp_q [$];
    int cyc = 0;
    int out_count = 0;
    int in_count = 0;
    int first_out_cyc = -1;
    int last_out_cyc = -1;
    int max_total = 0;
    int exp_hwm = 0;
    logic [63:0] last_out_data = '0;

    initial forever begin
        @(posedge clk);
        cyc++;
    end

    // Scoreboard monitor, sampled mid-cycle.
    initial begin
        int sz;
        int want_hwm;
        logic [63:0] e;
        forever begin
            @(negedge clk);
            if (!reset_n) begin
                exp_q.delete();
                exp_hwm = 0;
            end else begin
                sz = exp_q.size();
                if (sz > max_total) max_total = sz;
                if (sz > exp_hwm) exp_hwm = sz;
                want_hwm = HWM_EN ? exp_hwm : 0;
                vectors++;
                if (int'(total_count) !== sz) begin
                    miscompares++;
                    $display("FAIL total_count got=%0d required=%0d", total_count, sz);
                end
                vectors++;
                if (empty !== (sz == 0)) begin
                    miscompares++;
                    $display("FAIL empty got=%0b required=%0b", empty, (sz == 0));
                end
                vectors++;
                if (almost_full !== (sz >= 480)) begin
                    miscompares++;
                    $display("FAIL almost_full got=%0b required=%0b (count %0d)", almost_full, (sz >= 480), sz);
                end
                vectors++;
                if (int'(hwm) !== want_hwm) begin
                    miscompares++;
                    $display("FAIL hwm got=%0d required=%0d", hwm, want_hwm);
                end
                if (dut.ram_wren && dut.ram_rden && (dut.ram_wrad == dut.ram_rdad)) begin
                    vectors++;
                    miscompares++;
                    $display("FAIL ram_collision addr=%0d", dut.ram_wrad);
                end
                if (bus.in_valid && bus.in_ready) begin
                    exp_q.push_back(bus.in_data);
                    in_count++;
                end
                if (bus.out_valid && bus.out_ready) begin
                    vectors++;
                    if (exp_q.size() == 0) begin
                        miscompares++;
                        $display("FAIL out_unexpected got=%h required=no_word", bus.out_data);
                    end else begin
                        e = exp_q.pop_front();
                        if (bus.out_data !== e) begin
                            miscompares++;
                            $display("FAIL out_data got=%h required=%h", bus.out_data, e);
                        end
                    end
                    if (first_out_cyc < 0) first_out_cyc = cyc;
                    last_out_cyc = cyc;
                    last_out_data = bus.out_data;
                    out_count++;
                end
            end
        end
    end

    initial begin
        #1000000;
        $display("FAIL watchdog time limit reached");
        $fatal(1, "watchdog");
    end

    task automatic clear_stats();
        out_count = 0;
        in_count = 0;
        first_out_cyc = -1;
        last_out_cyc = -1;
        max_total = 0;
    endtask

    task automatic send(input logic [63:0] d);
        int t;
        @(posedge clk);
        #1;
        bus.in_valid = 1'b1;
        bus.in_data = d;
        t = 0;
        @(negedge clk);
        while (!bus.in_ready && t < 2000) begin
            @(negedge clk);
            t++;
        end
        if (t >= 2000) begin
            vectors++;
            miscompares++;
            $display("FAIL send_timeout got=in_ready_low required=accept data=%h", d);
            bus.in_valid = 1'b0;
        end
    endtask

    task automatic idle_in();
        @(posedge clk);
        #1;
        bus.in_valid = 1'b0;
    endtask

    task automatic drain(input bit toggle, input int budget);
        int t;
        t = 0;
        while (t < budget) begin
            @(posedge clk);
            #1;
            bus.out_ready = toggle ? ~bus.out_ready : 1'b1;
            @(negedge clk);
            if (empty === 1'b1 && exp_q.size() == 0) break;
            t++;
        end
        vectors++;
        if (t >= budget) begin
            miscompares++;
            $display("FAIL drain_timeout got=%0d_left required=0", exp_q.size());
        end
    endtask

    task automatic test_reset();
        bus.in_valid = 1'b0;
        bus.in_data = '0;
        bus.out_ready = 1'b0;
        reset_n = 1'b0;
        repeat (3) @(posedge clk);
        #1;
        vectors++;
        if (bus.in_ready !== 1'b0 || bus.out_valid !== 1'b0 || bus.out_data !== 64'd0 ||
            total_count !== 10'd0 || almost_full !== 1'b0 || empty !== 1'b1 || hwm !== 10'd0) begin
            miscompares++;
            $display("FAIL reset_state got=rdy%0b v%0b d%h cnt%0d af%0b e%0b hwm%0d required=0,0,0,0,0,1,0",
                     bus.in_ready, bus.out_valid, bus.out_data, total_count, almost_full, empty, hwm);
        end
        reset_n = 1'b1;
        @(posedge clk);
        @(negedge clk);
        vectors++;
        if (bus.in_ready !== 1'b1) begin
            miscompares++;
            $display("FAIL in_ready_after_reset got=%0b required=1", bus.in_ready);
        end
    endtask

    task automatic test_single();
        int first;
        clear_stats();
        first = -1;
        bus.out_ready = 1'b0;
        @(posedge clk);
        #1;
        bus.in_valid = 1'b1;
        bus.in_data = 64'hDEAD_BEEF_0000_0001;
        @(negedge clk);
        vectors++;
        if (bus.in_ready !== 1'b1) begin
            miscompares++;
            $display("FAIL single_accept got=%0b required=1", bus.in_ready);
        end
        @(posedge clk);
        #1;
        bus.in_valid = 1'b0;
        for (int k = 1; k <= 6; k++) begin
            @(negedge clk);
            if (k == 1) begin
                vectors++;
                if (empty !== 1'b0) begin
                    miscompares++;
                    $display("FAIL single_empty_drop got=%0b required=0", empty);
                end
            end
            if (bus.out_valid === 1'b1 && first < 0) first = k;
        end
        vectors++;
        if (first !== 4) begin
            miscompares++;
            $display("FAIL single_latency got=%0d required=4", first);
        end
        vectors++;
        if (bus.out_data !== 64'hDEAD_BEEF_0000_0001) begin
            miscompares++;
            $display("FAIL single_head got=%h required=%h", bus.out_data, 64'hDEAD_BEEF_0000_0001);
        end
        drain(1'b0, 20);
        vectors++;
        if (out_count !== 1) begin
            miscompares++;
            $display("FAIL single_count got=%0d required=1", out_count);
        end
    endtask

    task automatic test_stream();
        clear_stats();
        bus.out_ready = 1'b1;
        for (int i = 0; i < 1000; i++) begin
            send(64'h1000_0000_0000_0000 + 64'(i));
        end
        idle_in();
        drain(1'b0, 50);
        vectors++;
        if (out_count !== 1000) begin
            miscompares++;
            $display("FAIL stream_count got=%0d required=1000", out_count);
        end
        vectors++;
        if (last_out_cyc - first_out_cyc + 1 !== 1000) begin
            miscompares++;
            $display("FAIL stream_throughput got=%0d_cycles required=1000", last_out_cyc - first_out_cyc + 1);
        end
        vectors++;
        if (max_total > 4) begin
            miscompares++;
            $display("FAIL stream_max_total got=%0d required=<=4", max_total);
        end
    endtask

    task automatic test_full();
        clear_stats();
        bus.out_ready = 1'b0;
        for (int i = 0; i < 515; i++) begin
            send(64'hF000_0000_0000_0000 + 64'(i));
        end
        @(posedge clk);
        #1;
        bus.in_data = 64'hBAD0_BAD0_BAD0_BAD0;
        for (int k = 0; k < 5; k++) begin
            @(negedge clk);
            vectors++;
            if (bus.in_ready !== 1'b0) begin
                miscompares++;
                $display("FAIL full_in_ready got=%0b required=0", bus.in_ready);
            end
        end
        idle_in();
        @(negedge clk);
        vectors++;
        if (total_count !== 10'd515) begin
            miscompares++;
            $display("FAIL full_total got=%0d required=515", total_count);
        end
        vectors++;
        if (almost_full !== 1'b1) begin
            miscompares++;
            $display("FAIL full_almost_full got=%0b required=1", almost_full);
        end
        vectors++;
        if (in_count !== 515) begin
            miscompares++;
            $display("FAIL full_accepted got=%0d required=515", in_count);
        end
    endtask

    task automatic test_drain_toggle();
        out_count = 0;
        bus.out_ready = 1'b0;
        drain(1'b1, 3000);
        bus.out_ready = 1'b0;
        vectors++;
        if (out_count !== 515) begin
            miscompares++;
            $display("FAIL drain_count got=%0d required=515", out_count);
        end
        vectors++;
        if (empty !== 1'b1 || total_count !== 10'd0) begin
            miscompares++;
            $display("FAIL drain_end got=e%0b cnt%0d required=e1 cnt0", empty, total_count);
        end
    endtask

    task automatic test_reset_midstream();
        clear_stats();
        bus.out_ready = 1'b1;
        send(64'hA1);
        send(64'hA2);
        send(64'hA3);
        @(posedge clk);
        #3;
        bus.in_valid = 1'b0;
        reset_n = 1'b0;
        #1;
        vectors++;
        if (bus.in_ready !== 1'b0 || bus.out_valid !== 1'b0 || bus.out_data !== 64'd0 ||
            total_count !== 10'd0 || almost_full !== 1'b0 || empty !== 1'b1 || hwm !== 10'd0) begin
            miscompares++;
            $display("FAIL async_reset got=rdy%0b v%0b d%h cnt%0d af%0b e%0b hwm%0d required=0,0,0,0,0,1,0",
                     bus.in_ready, bus.out_valid, bus.out_data, total_count, almost_full, empty, hwm);
        end
        repeat (2) @(posedge clk);
        #1;
        reset_n = 1'b1;
        @(posedge clk);
        send(64'h5);
        idle_in();
        repeat (10) @(negedge clk);
        vectors++;
        if (out_count !== 1 || last_out_data !== 64'h5) begin
            miscompares++;
            $display("FAIL post_reset_out got=%0d_words last=%h required=1_word last=5", out_count, last_out_data);
        end
    endtask

    task automatic test_hwm();
        clear_stats();
        bus.out_ready = 1'b0;
        reset_n = 1'b0;
        repeat (2) @(posedge clk);
        #1;
        reset_n = 1'b1;
        @(posedge clk);
        for (int i = 0; i < 300; i++) begin
            send(64'h3000_0000_0000_0000 + 64'(i));
        end
        idle_in();
        repeat (3) @(negedge clk);
        vectors++;
        if (total_count !== 10'd300) begin
            miscompares++;
            $display("FAIL hwm_fill got=%0d required=300", total_count);
        end
        drain(1'b0, 400);
        vectors++;
        if (int'(hwm) !== (HWM_EN ? 300 : 0)) begin
            miscompares++;
            $display("FAIL hwm_held got=%0d required=%0d", hwm, (HWM_EN ? 300 : 0));
        end
        vectors++;
        if (out_count !== 300) begin
            miscompares++;
            $display("FAIL hwm_drain_count got=%0d required=300", out_count);
        end
    endtask

    initial begin
        test_reset();
        test_single();
        test_stream();
        test_full();
        test_drain_toggle();
        test_reset_midstream();
        test_hwm();
        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
